// File: rtl/riscv_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mc_pkg
// Purpose  : Shared types and encodings for the multi-cycle RISC-V control
//            path: FSM state encoding, major opcodes, ALU operand selects,
//            ALU operation class and result-bus select.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package riscv_mc_pkg;

    // 15 states in a 4-bit code; 4'hE is unused and TRAP sits at 4'hF so a
    // debugger can spot a trapped core at a glance.
    typedef enum logic [3:0] {
        S_FETCH  = 4'h0,
        S_DECODE = 4'h1,
        S_MEMADR = 4'h2,
        S_MEMRD  = 4'h3,
        S_MEMWB  = 4'h4,
        S_MEMWR  = 4'h5,
        S_EXE_R  = 4'h6,
        S_EXE_I  = 4'h7,
        S_ALUWB  = 4'h8,
        S_BRANCH = 4'h9,
        S_JAL    = 4'hA,
        S_JALR   = 4'hB,
        S_LINK   = 4'hC,
        S_UPPER  = 4'hD,
        S_TRAP   = 4'hF
    } state_t;

    // Major opcodes (IR[6:0])
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i      = 7'b0010011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;

    // ALU operand A select
    localparam logic [1:0] c_srca_pc    = 2'b00;
    localparam logic [1:0] c_srca_oldpc = 2'b01;
    localparam logic [1:0] c_srca_rs1   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] c_srcb_rb    = 2'b00;
    localparam logic [1:0] c_srcb_imm   = 2'b01;
    localparam logic [1:0] c_srcb_four  = 2'b10;

    // ALU operation class
    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_funct = 2'b10;

    // Result bus select
    localparam logic [1:0] c_res_aluout = 2'b00;
    localparam logic [1:0] c_res_data   = 2'b01;
    localparam logic [1:0] c_res_alu    = 2'b10;
    localparam logic [1:0] c_res_imm    = 2'b11;

    // Opcode dispatch out of DECODE; unknown opcodes land in TRAP.
    function automatic state_t decode_dispatch(input logic [6:0] op);
        state_t nxt;
        case (op)
            c_op_load, c_op_store: nxt = S_MEMADR;
            c_op_r:                nxt = S_EXE_R;
            c_op_i:                nxt = S_EXE_I;
            c_op_branch:           nxt = S_BRANCH;
            c_op_jal:              nxt = S_JAL;
            c_op_jalr:             nxt = S_JALR;
            c_op_lui, c_op_auipc:  nxt = S_UPPER;
            default:               nxt = S_TRAP;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_if
// Purpose  : Bundle between the control FSM and the datapath/memory side.
// Ports    : master (controller) - drives control strobes, reads opcode,
//            branch_taken and mem_ready.
//            slave (datapath/memory) - the mirror image.
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       retire;
    logic       illegal;
    logic       bus_err;
    logic [3:0] state_dbg;

    modport master (
        input  opcode, branch_taken, mem_ready,
        output mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, retire,
               illegal, bus_err, state_dbg
    );

    modport slave (
        output opcode, branch_taken, mem_ready,
        input  mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, retire,
               illegal, bus_err, state_dbg
    );
endinterface
`default_nettype wire

// File: rtl/mc_mem_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : mc_mem_watchdog
// Purpose  : Counts cycles a memory request waits for ready and flags the
//            cycle in which the wait reaches TIMEOUT_CYCLES. TIMEOUT_CYCLES=0
//            removes the counter entirely.
// Ports    : clk, rst     - clock, synchronous active-high reset
//            i_req        - memory request outstanding this cycle
//            i_ready      - memory completes this cycle
//            o_expire     - this waiting cycle is the limit (ready not seen)
// Revision : 1.0 - initial release
// ============================================================================
module mc_mem_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic i_ready,
    output logic o_expire
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_bypass
            assign o_expire = 1'b0;
        end else begin : g_count
            localparam int unsigned c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

            logic [c_cnt_w-1:0] r_cnt;

            // Any cycle without a pending wait restarts the count, so every
            // memory state starts from zero. The count never passes c_last
            // because expiry leaves the memory state.
            always_ff @(posedge clk) begin
                if (rst || !i_req || i_ready) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
            end

            // Ready in the limit cycle wins over the timeout.
            assign o_expire = i_req & ~i_ready & (r_cnt == c_last);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Main control FSM of the multi-cycle RISC-V core. Sequences the
//            shared datapath and the unified memory port, traps on illegal
//            opcodes and on memory timeouts.
// Ports    : clk, rst - clock, synchronous active-high reset
//            bus      - multicycle_ctrl_if.master: opcode/branch_taken/
//                       mem_ready in; memory handshake, datapath enables,
//                       mux selects, retire, sticky traps, state_dbg out
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import riscv_mc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    multicycle_ctrl_if.master        bus
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_illegal;
    logic       r_bus_err;

    logic       w_mem_state;
    logic       w_req;
    logic       w_expire;
    logic       w_set_illegal;
    logic       w_mem_we;
    logic       w_adr_src;
    logic       w_ir_write;
    logic       w_pc_write;
    logic       w_reg_write;
    logic [1:0] w_alu_a;
    logic [1:0] w_alu_b;
    logic [1:0] w_alu_op;
    logic [1:0] w_result;
    logic       w_retire;

    // The request depends on state only; keeping it out of the main
    // always_comb avoids a false loop through the watchdog.
    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                         (r_state == S_MEMWR);
    assign w_req       = w_mem_state & ~rst;

    mc_mem_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_req    (w_req),
        .i_ready  (bus.mem_ready),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (w_expire) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_set_illegal = 1'b0;
        w_mem_we      = 1'b0;
        w_adr_src     = 1'b0;
        w_ir_write    = 1'b0;
        w_pc_write    = 1'b0;
        w_reg_write   = 1'b0;
        w_alu_a       = c_srca_pc;
        w_alu_b       = c_srcb_rb;
        w_alu_op      = c_aluop_add;
        w_result      = c_res_aluout;
        w_retire      = 1'b0;

        case (r_state)
            S_FETCH: begin
                // ALU computes PC+4 and drives it straight onto the result bus.
                w_alu_b  = c_srcb_four;
                w_result = c_res_alu;
                if (bus.mem_ready) begin
                    w_ir_write  = 1'b1;
                    w_pc_write  = 1'b1;
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculative oldPC+imm into ALUOut for branch/JAL/AUIPC.
                w_alu_a     = c_srca_oldpc;
                w_alu_b     = c_srcb_imm;
                w_state_nxt = decode_dispatch(bus.opcode);
                if (w_state_nxt == S_TRAP) begin
                    w_set_illegal = 1'b1;
                end
            end
            S_MEMADR: begin
                w_alu_a     = c_srca_rs1;
                w_alu_b     = c_srcb_imm;
                // opcode[5] separates store (1) from load (0).
                w_state_nxt = bus.opcode[5] ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_adr_src = 1'b1;
                if (bus.mem_ready) begin
                    w_state_nxt = S_MEMWB;
                end
            end
            S_MEMWB: begin
                w_reg_write = 1'b1;
                w_result    = c_res_data;
                w_retire    = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_MEMWR: begin
                w_mem_we  = 1'b1;
                w_adr_src = 1'b1;
                if (bus.mem_ready) begin
                    w_retire    = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_EXE_R: begin
                w_alu_a     = c_srca_rs1;
                w_alu_b     = c_srcb_rb;
                w_alu_op    = c_aluop_funct;
                w_state_nxt = S_ALUWB;
            end
            S_EXE_I: begin
                w_alu_a     = c_srca_rs1;
                w_alu_b     = c_srcb_imm;
                w_alu_op    = c_aluop_funct;
                w_state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_result    = c_res_aluout;
                w_retire    = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                // ALU compares rs1/rs2 while ALUOut still holds the target.
                w_alu_a     = c_srca_rs1;
                w_alu_b     = c_srcb_rb;
                w_alu_op    = c_aluop_sub;
                w_result    = c_res_aluout;
                w_pc_write  = bus.branch_taken;
                w_retire    = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target from ALUOut; ALU refills ALUOut with
                // the link value oldPC+4 for ALUWB.
                w_pc_write  = 1'b1;
                w_result    = c_res_aluout;
                w_alu_a     = c_srca_oldpc;
                w_alu_b     = c_srcb_four;
                w_state_nxt = S_ALUWB;
            end
            S_JALR: begin
                w_alu_a     = c_srca_rs1;
                w_alu_b     = c_srcb_imm;
                w_result    = c_res_alu;
                w_pc_write  = 1'b1;
                w_state_nxt = S_LINK;
            end
            S_LINK: begin
                w_alu_a     = c_srca_oldpc;
                w_alu_b     = c_srcb_four;
                w_state_nxt = S_ALUWB;
            end
            S_UPPER: begin
                // LUI writes the immediate, AUIPC the oldPC+imm from DECODE.
                w_reg_write = 1'b1;
                w_result    = bus.opcode[5] ? c_res_imm : c_res_aluout;
                w_retire    = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_TRAP: begin
                w_state_nxt = S_TRAP;
            end
            default: begin
                w_state_nxt = S_TRAP;
            end
        endcase

        // A timed-out request is abandoned; mem_ready is low in that cycle,
        // so no enable above has fired.
        if (w_expire) begin
            w_state_nxt = S_TRAP;
        end
    end

    assign bus.mem_req    = w_req;
    assign bus.mem_we     = w_mem_we    & ~rst;
    assign bus.adr_src    = w_adr_src;
    assign bus.ir_write   = w_ir_write  & ~rst;
    assign bus.pc_write   = w_pc_write  & ~rst;
    assign bus.reg_write  = w_reg_write & ~rst;
    assign bus.alu_src_a  = w_alu_a;
    assign bus.alu_src_b  = w_alu_b;
    assign bus.alu_op     = w_alu_op;
    assign bus.result_src = w_result;
    assign bus.retire     = w_retire    & ~rst;
    assign bus.illegal    = r_illegal;
    assign bus.bus_err    = r_bus_err;
    assign bus.state_dbg  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Purpose  : Directed self-checking bench for multicycle_ctrl. One instance
//            with the default watchdog runs the instruction classes; a second
//            instance with TIMEOUT_CYCLES=4 exercises the bus-error trap.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    logic clk;
    logic rst;
    logic rst_wd;

    int n_checks;
    int n_errors;

    multicycle_ctrl_if u_bus ();
    multicycle_ctrl_if u_bus_wd ();

    multicycle_ctrl #(
        .TIMEOUT_CYCLES (255)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_bus.master)
    );

    multicycle_ctrl #(
        .TIMEOUT_CYCLES (4)
    ) u_dut_wd (
        .clk (clk),
        .rst (rst_wd),
        .bus (u_bus_wd.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check state and all control outputs of the main DUT in the current
    // cycle, then advance one clock. Inputs must already be set.
    task automatic exp_cyc(input string tag, input logic [3:0] st,
                           input logic mr, input logic we, input logic adr,
                           input logic irw, input logic pcw, input logic rw,
                           input logic [1:0] a, input logic [1:0] b,
                           input logic [1:0] op, input logic [1:0] rs,
                           input logic ret);
        #1;
        check({tag, ".state"}, 32'(u_bus.state_dbg), 32'(st));
        check({tag, ".ctl"},
              32'({u_bus.mem_req, u_bus.mem_we, u_bus.adr_src, u_bus.ir_write,
                   u_bus.pc_write, u_bus.reg_write, u_bus.alu_src_a,
                   u_bus.alu_src_b, u_bus.alu_op, u_bus.result_src,
                   u_bus.retire}),
              32'({mr, we, adr, irw, pcw, rw, a, b, op, rs, ret}));
        step();
    endtask

    task automatic fetch_ok(input string tag);
        exp_cyc({tag, ".fetch"}, 4'h0, 1,0,0,1,1,0, 2'b00,2'b10,2'b00,2'b10, 0);
    endtask

    task automatic decode_ok(input string tag);
        exp_cyc({tag, ".decode"}, 4'h1, 0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 0);
    endtask

    task automatic aluwb_ok(input string tag);
        exp_cyc({tag, ".aluwb"}, 4'h8, 0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        rst_wd   = 1'b1;
        u_bus.opcode          = 7'b0110011;
        u_bus.branch_taken    = 1'b0;
        u_bus.mem_ready       = 1'b1;
        u_bus_wd.opcode       = 7'b0110011;
        u_bus_wd.branch_taken = 1'b0;
        u_bus_wd.mem_ready    = 1'b0;

        // Reset held for three edges with mem_ready high: FETCH selects,
        // every enable forced low.
        step();
        exp_cyc("rst1", 4'h0, 0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 0);
        exp_cyc("rst2", 4'h0, 0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 0);
        check("rst.illegal", 32'(u_bus.illegal), 32'd0);
        check("rst.bus_err", 32'(u_bus.bus_err), 32'd0);
        rst = 1'b0;

        // R-type, zero wait: 4 cycles
        fetch_ok("r");
        decode_ok("r");
        exp_cyc("r.exe", 4'h6, 0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 0);
        aluwb_ok("r");

        // I-type
        u_bus.opcode = 7'b0010011;
        fetch_ok("i");
        decode_ok("i");
        exp_cyc("i.exe", 4'h7, 0,0,0,0,0,0, 2'b10,2'b01,2'b10,2'b00, 0);
        aluwb_ok("i");

        // Load with three wait cycles in MEMRD: 8 cycles total
        u_bus.opcode = 7'b0000011;
        fetch_ok("ld");
        decode_ok("ld");
        exp_cyc("ld.adr", 4'h2, 0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0);
        u_bus.mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_cyc("ld.wait", 4'h3, 1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0);
        end
        u_bus.mem_ready = 1'b1;
        exp_cyc("ld.rd", 4'h3, 1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0);
        exp_cyc("ld.wb", 4'h4, 0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b01, 1);

        // Store, zero wait: 4 cycles
        u_bus.opcode = 7'b0100011;
        fetch_ok("st");
        decode_ok("st");
        exp_cyc("st.adr", 4'h2, 0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0);
        exp_cyc("st.wr", 4'h5, 1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1);

        // Branch not taken, then taken
        u_bus.opcode = 7'b1100011;
        fetch_ok("bnt");
        decode_ok("bnt");
        exp_cyc("bnt.br", 4'h9, 0,0,0,0,0,0, 2'b10,2'b00,2'b01,2'b00, 1);
        fetch_ok("bt");
        decode_ok("bt");
        u_bus.branch_taken = 1'b1;
        exp_cyc("bt.br", 4'h9, 0,0,0,0,1,0, 2'b10,2'b00,2'b01,2'b00, 1);
        u_bus.branch_taken = 1'b0;

        // JAL
        u_bus.opcode = 7'b1101111;
        fetch_ok("jal");
        decode_ok("jal");
        exp_cyc("jal.jal", 4'hA, 0,0,0,0,1,0, 2'b01,2'b10,2'b00,2'b00, 0);
        aluwb_ok("jal");

        // JALR
        u_bus.opcode = 7'b1100111;
        fetch_ok("jalr");
        decode_ok("jalr");
        exp_cyc("jalr.jalr", 4'hB, 0,0,0,0,1,0, 2'b10,2'b01,2'b00,2'b10, 0);
        exp_cyc("jalr.link", 4'hC, 0,0,0,0,0,0, 2'b01,2'b10,2'b00,2'b00, 0);
        aluwb_ok("jalr");

        // LUI and AUIPC
        u_bus.opcode = 7'b0110111;
        fetch_ok("lui");
        decode_ok("lui");
        exp_cyc("lui.up", 4'hD, 0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b11, 1);
        u_bus.opcode = 7'b0010111;
        fetch_ok("auipc");
        decode_ok("auipc");
        exp_cyc("auipc.up", 4'hD, 0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 1);

        // Illegal opcode: TRAP, sticky, no requests even with mem_ready high
        u_bus.opcode = 7'h7F;
        fetch_ok("ill");
        check("ill.pre", 32'(u_bus.illegal), 32'd0);
        decode_ok("ill");
        exp_cyc("ill.trap1", 4'hF, 0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0);
        exp_cyc("ill.trap2", 4'hF, 0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0);
        check("ill.flag", 32'(u_bus.illegal), 32'd1);
        check("ill.bus_err", 32'(u_bus.bus_err), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("ill.clr", 32'(u_bus.illegal), 32'd0);
        check("ill.clr_state", 32'(u_bus.state_dbg), 32'h0);

        // Watchdog at limit 4: four waiting FETCH cycles then TRAP
        rst_wd = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("wd.wait_state", 32'(u_bus_wd.state_dbg), 32'h0);
            check("wd.wait_req", 32'(u_bus_wd.mem_req), 32'd1);
            check("wd.wait_err", 32'(u_bus_wd.bus_err), 32'd0);
            step();
        end
        #1;
        check("wd.trap_state", 32'(u_bus_wd.state_dbg), 32'hF);
        check("wd.bus_err", 32'(u_bus_wd.bus_err), 32'd1);
        check("wd.trap_req", 32'(u_bus_wd.mem_req), 32'd0);
        check("wd.illegal", 32'(u_bus_wd.illegal), 32'd0);
        step();
        step();
        #1;
        check("wd.sticky", 32'(u_bus_wd.bus_err), 32'd1);

        // Ready arriving in the limit cycle wins over the timeout
        rst_wd = 1'b1;
        step();
        rst_wd = 1'b0;
        #1;
        check("wd2.rst_err", 32'(u_bus_wd.bus_err), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
        end
        u_bus_wd.mem_ready = 1'b1;
        #1;
        check("wd2.irw", 32'(u_bus_wd.ir_write), 32'd1);
        step();
        #1;
        check("wd2.state", 32'(u_bus_wd.state_dbg), 32'h1);
        check("wd2.bus_err", 32'(u_bus_wd.bus_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
